// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial two's-complement subtractor: computes A - B one bit per clock,
// LSB first, with a registered borrow between bit slices. A start/busy/done
// handshake connects it to a controlling FSM. Results are held from one DONE
// to the next and never show partial values.
//
// Optional feature macro: SERIAL_SUB_OVF_EN
//   defined   -> ovf_out port exists and reports signed overflow of A - B
//   undefined -> ovf_out port and its logic are absent
//
// Handshake: start_in is accepted on a rising edge only in IDLE or DONE.
// After acceptance busy_out is high for exactly WIDTH cycles, then done_out
// pulses for one cycle while diff_out/borrow_out(/ovf_out) carry the new
// result. start_in while busy is ignored (no queuing). Holding start_in in
// DONE starts the next operation immediately (back-to-back).
//
// Ports:
//   clk_in        in   1      clock, rising edge
//   rst_in        in   1      synchronous active-high reset
//   start_in      in   1      request a new subtraction
//   a_in          in   WIDTH  minuend, sampled on the accepting edge
//   b_in          in   WIDTH  subtrahend, sampled on the accepting edge
//   busy_out      out  1      bit slices in progress
//   done_out      out  1      one-cycle result-valid pulse
//   diff_out      out  WIDTH  A - B modulo 2^WIDTH (held)
//   borrow_out    out  1      1 iff unsigned A < B (held)
//   ovf_out       out  1      signed overflow (only with SERIAL_SUB_OVF_EN)
//   state_dbg_out out  2      current FSM state (0=IDLE, 1=SHIFT, 2=DONE)
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf_out,
`endif
    output logic [1:0]       state_dbg_out
);

    // Counter counts 0..WIDTH-1 and exits at WIDTH-1, so clog2(WIDTH) bits
    // never wrap before the exit compare.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               brw_q, brw_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVF_EN
    logic               a_sign_q, a_sign_d;
    logic               b_sign_q, b_sign_d;
    logic               ovf_q, ovf_d;
`endif

    // One full-subtractor slice on the current LSBs.
    logic a0, b0, d_bit, brw_next;
    logic [WIDTH-1:0] res_shift;

    always_comb begin
        a0        = a_q[0];
        b0        = b_q[0];
        d_bit     = a0 ^ b0 ^ brw_q;
        brw_next  = (~a0 & b0) | (~(a0 ^ b0) & brw_q);
        res_shift = {d_bit, res_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        brw_d    = brw_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        a_sign_d = a_sign_q;
        b_sign_d = b_sign_q;
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // IDLE and DONE both accept a new operation; DONE lasts one
                // cycle either way.
                if (start_in) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    res_d   = '0;
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                    a_sign_d = a_in[WIDTH-1];
                    b_sign_d = b_in[WIDTH-1];
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shift;
                brw_d = brw_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Publish on the same edge the last slice completes, so
                    // the held outputs jump straight from old to new result.
                    diff_d   = res_shift;
                    borrow_d = brw_next;
                    state_d  = ST_DONE;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d = (a_sign_q != b_sign_q) && (d_bit != a_sign_q);
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            brw_q    <= brw_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
            a_sign_q <= a_sign_d;
            b_sign_q <= b_sign_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy_out      = (state_q == ST_SHIFT);
    assign done_out      = (state_q == ST_DONE);
    assign diff_out      = diff_q;
    assign borrow_out    = borrow_q;
    assign state_dbg_out = state_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf_out       = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit two's-complement subtractor computing A − B one bit per clock, LSB first, with a registered borrow flip-flop between bit slices. It is the subtract-direction counterpart of the team's ripple full-adder datapath. It serves area-constrained paths where a WIDTH-wide parallel subtractor is not justified. A start/busy/done handshake connects it to a controlling FSM, and results are held until the next operation.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..64.
- clk_in  input  1  single clock; all state updates on its rising edge.
- rst_in  input  1  synchronous, active-high reset.
- start_in  input  1  request a new subtraction; sampled on the rising edge.
- a_in  input  WIDTH  minuend; sampled only on the edge that accepts start_in.
- b_in  input  WIDTH  subtrahend; sampled only on the edge that accepts start_in.
- busy_out  output  1  high while bit slices are being processed.
- done_out  output  1  one-cycle pulse when diff_out and borrow_out become valid.
- diff_out  output  WIDTH  A − B modulo 2^WIDTH.
- borrow_out  output  1  final borrow; 1 iff unsigned A < B.
- ovf_out  output  1  signed overflow; exists only with SERIAL_SUB_OVF_EN.

## Operation
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE:**
  - With start_in=1: load a_in and b_in into shift registers, clear the borrow FF, clear the bit counter, and go to SHIFT.
  - With start_in=0: stay in IDLE.
- **SHIFT, each cycle:**
  - a0/b0 = LSB of the A/B shift registers; br = borrow FF.
  - Difference bit d = a0 ^ b0 ^ br.
  - Next borrow = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d shifts into the MSB of the result shift register; A and B shift right by one.
  - The counter increments. On the WIDTH-th slice (counter = WIDTH−1), go to DONE.
- **DONE:**
  - diff_out = result register; borrow_out = borrow FF.
  - done_out = 1 for this cycle only.
  - Go to IDLE, or, if start_in=1, perform the IDLE load and go to SHIFT (back-to-back accept).
- start_in while in SHIFT is ignored; no queuing.
- diff_out, borrow_out and ovf_out hold their values from DONE until the next DONE. They never show partial results.
- Bit counter width is clog2(WIDTH); it must not wrap before the exit compare.

## Timing
- **Reset values:** on rst_in=1 at an edge, state=IDLE. busy_out=0, done_out=0, diff_out=0, borrow_out=0, ovf_out=0. Shift registers, counter and borrow FF are cleared.
- **Reset priority:** reset has priority over start_in and over any in-progress operation. A reset mid-SHIFT aborts with no done_out pulse, and the outputs read 0.
- **Acceptance:** start_in is accepted at edge k.
  - busy_out=1 after edges k .. k+WIDTH−1, i.e. for exactly WIDTH cycles.
  - done_out=1 and the outputs update after edge k+WIDTH.
  - Latency is WIDTH+1 edges from acceptance to results.
- **Throughput:** with back-to-back starts, one result every WIDTH+1 cycles.
- busy_out is 0 in IDLE and DONE. done_out is never high while busy_out=1.
- a_in and b_in may change freely after the accepting edge.

## Configuration
- Macro: SERIAL_SUB_OVF_EN.
- **Defined:**
  - The ovf_out port exists.
  - Sign bits of A and B are captured at load.
  - In DONE, ovf_out = (a_sign != b_sign) && (diff_out[WIDTH−1] != a_sign).
  - ovf_out is held like diff_out and reset to 0.
- **Undefined:** the ovf_out port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8.
- **Simple positive result:** reset, then start with a=0x05, b=0x03 -> done_out pulses at edge k+8; diff=0x02, borrow=0; ovf=0 if enabled.
- **Unsigned borrow:** a=0x03, b=0x05 -> diff=0xFE, borrow=1. Next, a=0x00, b=0x00 -> diff=0x00, borrow=0.
- **Signed overflow (SERIAL_SUB_OVF_EN):** a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1. Then a=0x7F, b=0xFF -> diff=0x80, borrow=1, ovf=1.
- **Start during SHIFT:** start with a=0x10, b=0x01, then assert start_in with a=0xAA, b=0x55 at cycle k+3 -> ignored; diff=0x0F at k+8; exactly one done_out pulse.
- **Back-to-back:** hold start_in=1 through DONE with new operands a=0x20, b=0x30 -> second op accepted in DONE; second done_out at 9 edges later; diff=0xF0, borrow=1.
- **Reset mid-operation:** assert rst_in at cycle k+4 of a=0xFF, b=0x01 -> busy_out=0, diff_out=0, no done_out pulse. A subsequent start with a=0x09, b=0x04 yields diff=0x05 normally.
